// File: rtl/pipe_regfile_pkg.sv
// Shared constants and types for the pipeline register file.
// Optional forwarding is selected by macro PIPE_REGFILE_BYPASS_EN.
package pipe_regfile_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_NREGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/pipe_regfile_if.sv
// Pipeline-facing bus of the register file: read, writeback, debug and issue ports.
// The master side is the pipeline; the slave side is the register file.
interface pipe_regfile_if
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS)
);

  logic [ADDR_W-1:0] r0addr;
  logic [ADDR_W-1:0] r1addr;
  logic [DATA_W-1:0] r0data;
  logic [DATA_W-1:0] r1data;

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wena;

  logic [ADDR_W-1:0] swaddr;
  logic [DATA_W-1:0] swdata;
  logic              swena;
  logic [DATA_W-1:0] dff;

  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ena;
  logic              hazard;
  logic [NREGS-1:0]  busy;

  modport master (
    output r0addr, r1addr, waddr, wdata, wena, swaddr, swdata, swena,
           iss_addr, iss_ena,
    input  r0data, r1data, dff, hazard, busy
  );

  modport slave (
    input  r0addr, r1addr, waddr, wdata, wena, swaddr, swdata, swena,
           iss_addr, iss_ena,
    output r0data, r1data, dff, hazard, busy
  );

endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// Scoreboard: per-register pending bits and the operand hazard flag.
// PIPE_REGFILE_BYPASS_EN lets an in-flight writeback cancel the hazard.
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              iss_ena,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wena,
  input  logic [ADDR_W-1:0] r0addr,
  input  logic [ADDR_W-1:0] r1addr,
  output logic [NREGS-1:0]  busy,
  output logic              hazard
);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy_next;
  logic             clr0;
  logic             clr1;

  // Set dominates clear so a newly issued producer keeps the register pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_ena) set_mask[iss_addr] = 1'b1;
    if (wena)    clr_mask[waddr]    = 1'b1;
    busy_next = ((busy & ~clr_mask) | set_mask) & {{(NREGS-1){1'b1}}, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

`ifdef PIPE_REGFILE_BYPASS_EN
  assign clr0 = wena && (waddr == r0addr);
  assign clr1 = wena && (waddr == r1addr);
`else
  assign clr0 = 1'b0;
  assign clr1 = 1'b0;
`endif

  assign hazard = (busy[r0addr] & ~clr0) | (busy[r1addr] & ~clr1);

endmodule

// File: rtl/pipe_regfile.sv
// Pipeline register file: two read ports, writeback and debug write ports, issue scoreboard.
// Define PIPE_REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input logic           clk,
  input logic           rst_n,
  pipe_regfile_if.slave bus
);

  logic [DATA_W-1:0] mem [NREGS];

  // Register 0 is never written; the debug port wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (bus.swena && (bus.swaddr == ADDR_W'(i)))
          mem[i] <= bus.swdata;
        else if (bus.wena && (bus.waddr == ADDR_W'(i)))
          mem[i] <= bus.wdata;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem[a];
`ifdef PIPE_REGFILE_BYPASS_EN
    if (bus.swena && (bus.swaddr == a))
      v = bus.swdata;
    else if (bus.wena && (bus.waddr == a))
      v = bus.wdata;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  assign bus.r0data = read_port(bus.r0addr);
  assign bus.r1data = read_port(bus.r1addr);
  assign bus.dff    = read_port(bus.swaddr);

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_addr (bus.iss_addr),
    .iss_ena  (bus.iss_ena),
    .waddr    (bus.waddr),
    .wena     (bus.wena),
    .r0addr   (bus.r0addr),
    .r1addr   (bus.r1addr),
    .busy     (bus.busy),
    .hazard   (bus.hazard)
  );

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed self-checking bench for pipe_regfile (default 64-bit, 32-register build).
// Expectations follow PIPE_REGFILE_BYPASS_EN when the bench is built with it.
module tb_pipe_regfile;
  import pipe_regfile_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned NR = DEF_NREGS;
  localparam int unsigned AW = DEF_ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  pipe_regfile_if #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) bus ();

  pipe_regfile #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.wena = 1'b0; bus.swena = 1'b0; bus.iss_ena = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reg_addr_t a;
    rst_n = 1'b0;
    bus.r0addr = '0; bus.r1addr = '0;
    bus.waddr = '0; bus.wdata = '0; bus.wena = 1'b0;
    bus.swaddr = '0; bus.swdata = '0; bus.swena = 1'b0;
    bus.iss_addr = '0; bus.iss_ena = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state: everything reads zero, nothing pending
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_hazard", 64'(bus.hazard), 64'h0);
    for (int i = 0; i < 32; i++) begin
      a = reg_addr_t'(i);
      bus.r0addr = a; bus.r1addr = ~a; bus.swaddr = a;
      #1;
      check($sformatf("rst_r0_%0d", i), bus.r0data, 64'h0);
      check($sformatf("rst_r1_%0d", i), bus.r1data, 64'h0);
      check($sformatf("rst_dff_%0d", i), bus.dff, 64'h0);
      check($sformatf("rst_hz_%0d", i), 64'(bus.hazard), 64'h0);
    end

    // Same-address writes on both ports: software port wins
    bus.r0addr = 5'd0; bus.r1addr = 5'd0;
    bus.wena = 1'b1; bus.waddr = 5'd5; bus.wdata = 64'hA5;
    bus.swena = 1'b1; bus.swaddr = 5'd5; bus.swdata = 64'h3C;
    tick(); idle();
    bus.r0addr = 5'd5; #1;
    check("collide_r0", bus.r0data, 64'h3C);

    // Writes to register 0 are dropped on both ports
    bus.wena = 1'b1; bus.waddr = 5'd0; bus.wdata = 64'h7;
    bus.swena = 1'b1; bus.swaddr = 5'd0; bus.swdata = 64'hF;
    tick(); idle();
    bus.r0addr = 5'd0; #1;
    check("zero_r0", bus.r0data, 64'h0);
    check("zero_dff", bus.dff, 64'h0);

    // Different addresses: both written
    bus.wena = 1'b1; bus.waddr = 5'd10; bus.wdata = 64'h1111_2222_3333_4444;
    bus.swena = 1'b1; bus.swaddr = 5'd11; bus.swdata = 64'hDEAD_BEEF_0000_0022;
    tick(); idle();
    bus.r0addr = 5'd10; bus.r1addr = 5'd11; bus.swaddr = 5'd10; #1;
    check("dual_r0", bus.r0data, 64'h1111_2222_3333_4444);
    check("dual_r1", bus.r1data, 64'hDEAD_BEEF_0000_0022);
    check("dual_dff", bus.dff, 64'h1111_2222_3333_4444);

    // Issue then writeback on register 3
    bus.r0addr = 5'd0; bus.r1addr = 5'd0;
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd3;
    tick(); idle();
    bus.r0addr = 5'd3; #1;
    check("iss3_busy", 64'(bus.busy), 64'h8);
    check("iss3_hazard", 64'(bus.hazard), 64'h1);
    bus.wena = 1'b1; bus.waddr = 5'd3; bus.wdata = 64'h9; #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    check("wb3_inflight_hz", 64'(bus.hazard), 64'h0);
    check("wb3_inflight_r0", bus.r0data, 64'h9);
`else
    check("wb3_inflight_hz", 64'(bus.hazard), 64'h1);
    check("wb3_inflight_r0", bus.r0data, 64'h0);
`endif
    tick(); idle(); #1;
    check("wb3_hazard", 64'(bus.hazard), 64'h0);
    check("wb3_r0", bus.r0data, 64'h9);
    check("wb3_busy", 64'(bus.busy), 64'h0);

    // Issue to register 0 never marks it busy
    bus.r0addr = 5'd0;
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd0;
    tick(); idle(); #1;
    check("iss0_busy", 64'(bus.busy), 64'h0);
    check("iss0_hazard", 64'(bus.hazard), 64'h0);

    // Issue and writeback to register 7 in one edge: stays pending
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd7;
    bus.wena = 1'b1; bus.waddr = 5'd7; bus.wdata = 64'h77;
    tick(); idle();
    bus.r1addr = 5'd7; #1;
    check("iss_wb7_busy", 64'(bus.busy), 64'h80);
    check("iss_wb7_hazard", 64'(bus.hazard), 64'h1);
    check("iss_wb7_r1", bus.r1data, 64'h77);
    bus.r1addr = 5'd0;
    bus.wena = 1'b1; bus.waddr = 5'd7; bus.wdata = 64'h78;
    tick(); idle(); #1;
    check("clr7_busy", 64'(bus.busy), 64'h0);

    // Debug writes leave the scoreboard untouched
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd8;
    tick(); idle();
    bus.swena = 1'b1; bus.swaddr = 5'd8; bus.swdata = 64'h88;
    tick(); idle(); #1;
    check("sw8_busy", 64'(bus.busy), 64'h100);
    check("sw8_dff", bus.dff, 64'h88);
    bus.wena = 1'b1; bus.waddr = 5'd8; bus.wdata = 64'h8;
    tick(); idle(); #1;
    check("clr8_busy", 64'(bus.busy), 64'h0);

    // Read during writeback to a pending register
    bus.wena = 1'b1; bus.waddr = 5'd4; bus.wdata = 64'h44;
    tick(); idle();
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd4;
    tick(); idle();
    bus.r0addr = 5'd0; bus.r1addr = 5'd4; bus.swaddr = 5'd4;
    bus.wena = 1'b1; bus.waddr = 5'd4; bus.wdata = 64'h55; #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    check("byp4_r1", bus.r1data, 64'h55);
    check("byp4_hazard", 64'(bus.hazard), 64'h0);
    check("byp4_dff", bus.dff, 64'h55);
`else
    check("byp4_r1", bus.r1data, 64'h44);
    check("byp4_hazard", 64'(bus.hazard), 64'h1);
    check("byp4_dff", bus.dff, 64'h44);
`endif
    tick(); idle(); #1;
    check("wb4_r1", bus.r1data, 64'h55);
    check("wb4_hazard", 64'(bus.hazard), 64'h0);

    // Both ports writing register 12 while it is read
    bus.r0addr = 5'd12; bus.r1addr = 5'd0;
    bus.wena = 1'b1; bus.waddr = 5'd12; bus.wdata = 64'hC1;
    bus.swena = 1'b1; bus.swaddr = 5'd12; bus.swdata = 64'hC2; #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    check("byp12_r0", bus.r0data, 64'hC2);
`else
    check("byp12_r0", bus.r0data, 64'h0);
`endif
    tick(); idle(); #1;
    check("wb12_r0", bus.r0data, 64'hC2);

    // Reset mid-operation discards pending state and same-cycle writes
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd2;
    tick();
    bus.iss_addr = 5'd6;
    tick(); idle(); #1;
    check("pre_rst_busy", 64'(bus.busy), 64'h44);
    rst_n = 1'b0;
    bus.wena = 1'b1; bus.waddr = 5'd9; bus.wdata = 64'h99;
    bus.swena = 1'b1; bus.swaddr = 5'd13; bus.swdata = 64'hD;
    bus.iss_ena = 1'b1; bus.iss_addr = 5'd13;
    tick(); idle();
    rst_n = 1'b1;
    bus.r0addr = 5'd2; bus.r1addr = 5'd6; #1;
    check("post_rst_busy", 64'(bus.busy), 64'h0);
    check("post_rst_hazard", 64'(bus.hazard), 64'h0);
    for (int i = 0; i < 32; i++) begin
      a = reg_addr_t'(i);
      bus.r0addr = a; bus.swaddr = a;
      #1;
      check($sformatf("post_rst_r0_%0d", i), bus.r0data, 64'h0);
      check($sformatf("post_rst_dff_%0d", i), bus.dff, 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
